// File: rtl/spi_cmd_decoder_pkg.sv
// Opcodes, waveform codes and decoder state type, shared with the pulse core.
package spi_cmd_decoder_pkg;

  // Data-carrying opcodes (each followed by a 16-bit word, low byte first)
  localparam logic [7:0] OP_TON   = 8'h91;
  localparam logic [7:0] OP_TOFF  = 8'h9E;
  localparam logic [7:0] OP_WAVE  = 8'h9C;
  localparam logic [7:0] OP_IP    = 8'h93;
  // Single-byte machine control opcodes
  localparam logic [7:0] OP_START = 8'h06;
  localparam logic [7:0] OP_STOP  = 8'h07;

  // Waveform select codes accepted by the pulse generator core
  localparam logic [15:0] WAVE_RES_CO = 16'h8000;
  localparam logic [15:0] WAVE_2001   = 16'h2001;
  localparam logic [15:0] WAVE_2002   = 16'h2002;
  localparam logic [15:0] WAVE_6001   = 16'h6001;
  localparam logic [15:0] WAVE_4001   = 16'h4001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GET_LO = 2'd1,
    ST_GET_HI = 2'd2
  } dec_state_t;

  // True for opcodes that expect two data bytes
  function automatic logic is_data_opcode(input logic [7:0] op);
    return (op == OP_TON) || (op == OP_TOFF) || (op == OP_WAVE) || (op == OP_IP);
  endfunction

  // True for waveform codes the pulse core understands
  function automatic logic is_valid_wave(input logic [15:0] code);
    return (code == WAVE_RES_CO) || (code == WAVE_2001) || (code == WAVE_2002) ||
           (code == WAVE_6001) || (code == WAVE_4001);
  endfunction

endpackage

// File: rtl/spi_cmd_timeout.sv
// Inter-byte watchdog: counts idle cycles while a command is open.
module spi_cmd_timeout #(
  parameter int LIMIT = 50000
) (
  input  logic clk_in,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_reg;

  // Clear has priority; the count holds at LIMIT so it can never wrap.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && (count_reg != CNT_W'(LIMIT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CNT_W'(LIMIT));

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frames SPI command bytes, validates values and drives the held pulse
// parameters plus start/stop/error strobes (all registered, one cycle late).
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] TON_DEFAULT    = 16'd100,
  parameter logic [15:0] TOFF_DEFAULT   = 16'd50,
  parameter logic [15:0] WAVE_DEFAULT   = 16'h8000,
  parameter logic [15:0] IP_DEFAULT     = 16'd0
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [15:0] ton_us,
  output logic [15:0] toff_us,
  output logic [15:0] waveform,
  output logic [15:0] ip_set,
  output logic        param_update,
  output logic        machine_start,
  output logic        machine_stop,
  output logic        cmd_error,
  output logic [7:0]  err_count,
  output logic        busy
);

  dec_state_t  state_reg, state_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic [7:0]  lo_reg, lo_next;
  logic [15:0] ton_reg, ton_next;
  logic [15:0] toff_reg, toff_next;
  logic [15:0] wave_reg, wave_next;
  logic [15:0] ip_reg, ip_next;
  logic        upd_reg, upd_next;
  logic        start_reg, start_next;
  logic        stop_reg, stop_next;
  logic        err_reg, err_next;
  logic [7:0]  err_count_reg, err_count_next;
  logic [15:0] word;
  logic        expired;

  // Watchdog is held clear in IDLE and on every received byte
  spi_cmd_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in    (clk_in),
    .sys_rst_n (sys_rst_n),
    .clear     (rx_valid || (state_reg == ST_IDLE)),
    .run       (state_reg != ST_IDLE),
    .expired   (expired)
  );

  assign word = {rx_byte, lo_reg};

  // State and output registers; parameters reset to their defaults
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= ST_IDLE;
      opcode_reg    <= '0;
      lo_reg        <= '0;
      ton_reg       <= TON_DEFAULT;
      toff_reg      <= TOFF_DEFAULT;
      wave_reg      <= WAVE_DEFAULT;
      ip_reg        <= IP_DEFAULT;
      upd_reg       <= 1'b0;
      start_reg     <= 1'b0;
      stop_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      opcode_reg    <= opcode_next;
      lo_reg        <= lo_next;
      ton_reg       <= ton_next;
      toff_reg      <= toff_next;
      wave_reg      <= wave_next;
      ip_reg        <= ip_next;
      upd_reg       <= upd_next;
      start_reg     <= start_next;
      stop_reg      <= stop_next;
      err_reg       <= err_next;
      err_count_reg <= err_count_next;
    end
  end

  // Byte framing, validation and commit; rx_valid outranks the timeout
  always_comb begin
    state_next  = state_reg;
    opcode_next = opcode_reg;
    lo_next     = lo_reg;
    ton_next    = ton_reg;
    toff_next   = toff_reg;
    wave_next   = wave_reg;
    ip_next     = ip_reg;
    upd_next    = 1'b0;
    start_next  = 1'b0;
    stop_next   = 1'b0;
    err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (rx_valid) begin
          if (is_data_opcode(rx_byte)) begin
            opcode_next = rx_byte;
            state_next  = ST_GET_LO;
          end else if (rx_byte == OP_START) begin
            start_next = 1'b1;
          end else if (rx_byte == OP_STOP) begin
            stop_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_GET_LO: begin
        if (rx_valid) begin
          lo_next    = rx_byte;
          state_next = ST_GET_HI;
        end else if (expired) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end
      end
      ST_GET_HI: begin
        if (rx_valid) begin
          state_next = ST_IDLE;
          // A rejected value leaves the held register untouched
          case (opcode_reg)
            OP_TON:  if (word != '0)          begin ton_next  = word; upd_next = 1'b1; end
                     else                     err_next = 1'b1;
            OP_TOFF: if (word != '0)          begin toff_next = word; upd_next = 1'b1; end
                     else                     err_next = 1'b1;
            OP_WAVE: if (is_valid_wave(word)) begin wave_next = word; upd_next = 1'b1; end
                     else                     err_next = 1'b1;
            OP_IP:   if (word != '0)          begin ip_next   = word; upd_next = 1'b1; end
                     else                     err_next = 1'b1;
            default: err_next = 1'b1;
          endcase
        end else if (expired) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Error counter moves together with the cmd_error pulse and saturates
    err_count_next = err_count_reg;
    if (err_next && (err_count_reg != 8'hFF)) begin
      err_count_next = err_count_reg + 8'd1;
    end
  end

  assign ton_us        = ton_reg;
  assign toff_us       = toff_reg;
  assign waveform      = wave_reg;
  assign ip_set        = ip_reg;
  assign param_update  = upd_reg;
  assign machine_start = start_reg;
  assign machine_stop  = stop_reg;
  assign cmd_error     = err_reg;
  assign err_count     = err_count_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

  logic        clk_in;
  logic        sys_rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [15:0] ton_us, toff_us, waveform, ip_set;
  logic        param_update, machine_start, machine_stop, cmd_error, busy;
  logic [7:0]  err_count;

  int n_checks;
  int n_errors;

  spi_cmd_decoder dut (
    .clk_in        (clk_in),
    .sys_rst_n     (sys_rst_n),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .ton_us        (ton_us),
    .toff_us       (toff_us),
    .waveform      (waveform),
    .ip_set        (ip_set),
    .param_update  (param_update),
    .machine_start (machine_start),
    .machine_stop  (machine_stop),
    .cmd_error     (cmd_error),
    .err_count     (err_count),
    .busy          (busy)
  );

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One-cycle rx_valid strobe; returns on the falling edge after capture,
  // where the registered response to this byte is already visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] value);
    send_byte(op);
    send_byte(value[7:0]);
    send_byte(value[15:8]);
  endtask

  int cycles;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk_in);

    // Reset state
    check("rst_ton",   32'(ton_us),   100);
    check("rst_toff",  32'(toff_us),  50);
    check("rst_wave",  32'(waveform), 32'h8000);
    check("rst_ip",    32'(ip_set),   0);
    check("rst_errc",  32'(err_count), 0);
    check("rst_strb",  32'({param_update, machine_start, machine_stop, cmd_error}), 0);
    check("rst_busy",  32'(busy),     0);
    sys_rst_n = 1'b1;
    @(negedge clk_in);

    // Ton = 100, param_update is a single pulse
    send_cmd(8'h91, 16'd100);
    check("ton100",     32'(ton_us), 100);
    check("ton100_upd", 32'(param_update), 1);
    @(negedge clk_in);
    check("ton100_upd_off", 32'(param_update), 0);

    // Ton = 0x1234, mid-command busy and no early commit
    send_byte(8'h91);
    check("busy_lo", 32'(busy), 1);
    send_byte(8'h34);
    check("busy_hi", 32'(busy), 1);
    check("ton_hold_mid", 32'(ton_us), 100);
    send_byte(8'h12);
    check("ton1234", 32'(ton_us), 32'h1234);
    check("busy_done", 32'(busy), 0);

    // Toff = 50, then data bytes equal to start/stop opcodes stay data
    send_cmd(8'h9E, 16'd50);
    check("toff50", 32'(toff_us), 50);
    send_byte(8'h9E);
    send_byte(8'h06);
    check("data06_nostart", 32'(machine_start), 0);
    send_byte(8'h07);
    check("data07_nostop", 32'(machine_stop), 0);
    check("toff0706", 32'(toff_us), 32'h0706);

    // Valid waveform, then an invalid one is rejected
    send_cmd(8'h9C, 16'h4001);
    check("wave4001", 32'(waveform), 32'h4001);
    send_cmd(8'h9C, 16'h0005);
    check("wave_keep", 32'(waveform), 32'h4001);
    check("wave_err",  32'(cmd_error), 1);
    check("wave_noupd", 32'(param_update), 0);
    check("wave_errc", 32'(err_count), 1);
    @(negedge clk_in);
    check("wave_err_off", 32'(cmd_error), 0);

    // Zero Ton is rejected
    send_cmd(8'h91, 16'h0000);
    check("ton0_keep", 32'(ton_us), 32'h1234);
    check("ton0_err",  32'(cmd_error), 1);
    check("ton0_errc", 32'(err_count), 2);

    // Ip = 60, then start and stop strobes
    send_cmd(8'h93, 16'd60);
    check("ip60", 32'(ip_set), 60);
    send_byte(8'h06);
    check("start_on", 32'(machine_start), 1);
    check("start_nostop", 32'(machine_stop), 0);
    @(negedge clk_in);
    check("start_off", 32'(machine_start), 0);
    send_byte(8'h07);
    check("stop_on", 32'(machine_stop), 1);
    @(negedge clk_in);
    check("stop_off", 32'(machine_stop), 0);

    // Timeout after the low byte: idle drops after TIMEOUT_CYCLES+1 edges
    send_byte(8'h93);
    send_byte(8'h3C);
    cycles = 0;
    for (int i = 1; i <= 60000; i++) begin
      @(negedge clk_in);
      if (!busy) begin
        cycles = i;
        break;
      end
    end
    check("tmo_cycles", 32'(cycles), 50001);
    check("tmo_err",    32'(cmd_error), 1);
    check("tmo_errc",   32'(err_count), 3);
    check("tmo_ip_keep", 32'(ip_set), 60);
    send_byte(8'h06);
    check("tmo_then_start", 32'(machine_start), 1);

    // Unknown opcode flood saturates the error counter
    send_byte(8'hAA);
    check("unk_err",  32'(cmd_error), 1);
    check("unk_errc", 32'(err_count), 4);
    for (int i = 1; i < 300; i++) send_byte(8'hAA);
    check("errc_sat", 32'(err_count), 255);
    send_byte(8'hAA);
    check("errc_hold", 32'(err_count), 255);

    // Asynchronous reset while in GET_HI
    send_byte(8'h91);
    send_byte(8'h10);
    check("pre_rst_busy", 32'(busy), 1);
    #3 sys_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_ton",  32'(ton_us), 100);
    check("arst_toff", 32'(toff_us), 50);
    check("arst_wave", 32'(waveform), 32'h8000);
    check("arst_ip",   32'(ip_set), 0);
    check("arst_errc", 32'(err_count), 0);
    @(negedge clk_in);
    sys_rst_n = 1'b1;

    // Decoder is usable again after reset
    send_byte(8'h07);
    check("post_rst_stop", 32'(machine_stop), 1);
    check("post_rst_ton",  32'(ton_us), 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Converts the SPI slave's received byte stream into the EDM pulse-generator parameter set and machine control strobes. It sits directly downstream of the SPI byte receiver and upstream of the discharge waveform/timing core inside fpga_slave. The decoder frames the command protocol: one opcode byte, followed where required by a 16-bit data word sent low byte first. It validates each command, commits the values to held output registers, and reports framing and content errors.

Parameters:
TIMEOUT_CYCLES, 50000, max clk_in cycles allowed between bytes of one command (1 ms at 50 MHz)
TON_DEFAULT, 16'd100, reset value of ton_us
TOFF_DEFAULT, 16'd50, reset value of toff_us
WAVE_DEFAULT, 16'h8000, reset waveform (RES_CO discharge)
IP_DEFAULT, 16'd0, reset value of ip_set

Ports:
clk_in  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  byte from SPI receiver, valid only with rx_valid
rx_valid  input  1  single-cycle strobe, one per received byte
ton_us  output  16  pulse on-time, microseconds
toff_us  output  16  pulse off-time, microseconds
waveform  output  16  waveform select code
ip_set  output  16  peak current setpoint, raw code (amps = code/2)
param_update  output  1  1-cycle pulse when any parameter is committed
machine_start  output  1  1-cycle start strobe
machine_stop  output  1  1-cycle stop strobe
cmd_error  output  1  1-cycle pulse on any rejected or aborted command
err_count  output  8  saturating count of cmd_error events
busy  output  1  high while a multi-byte command is in progress

Behaviour:
- Reset: async assert. ton_us, toff_us, waveform and ip_set load their *_DEFAULT values. All strobes are 0, err_count is 0, state is IDLE, and the timeout counter is 0.
- Opcodes:
  - 0x91 Ton, 0x9E Toff, 0x9C waveform and 0x93 Ip each take 2 data bytes.
  - 0x06 start and 0x07 stop are single-byte commands.
- FSM states: IDLE, GET_LO, GET_HI.
  - IDLE + rx_valid + data opcode: latch the opcode and go to GET_LO.
  - IDLE + rx_valid + 0x06 or 0x07: pulse machine_start or machine_stop on the next cycle and stay in IDLE.
  - IDLE + rx_valid + unknown opcode: pulse cmd_error and stay in IDLE.
  - GET_LO + rx_valid: latch the low byte and go to GET_HI.
  - GET_HI + rx_valid: form {rx_byte, lo}, validate it, commit it and return to IDLE.
- Byte interpretation: in GET_LO/GET_HI every byte is treated as data, even if its value matches an opcode. Framing is by byte count only.
- Commit latency: the output register and param_update assert one cycle after the final rx_valid. The new value holds until the next commit or reset.
- Validation:
  - Waveform must be one of 0x8000, 0x2001, 0x2002, 0x6001 or 0x4001.
  - Ton, Toff and Ip must be non-zero.
  - A failing value is not committed: the old value is kept, cmd_error pulses and param_update stays 0.
- Timeout:
  - The counter clears on every rx_valid and in IDLE, and increments in GET_LO/GET_HI.
  - When the count reaches TIMEOUT_CYCLES, go to IDLE, pulse cmd_error and discard the partial command.
  - If rx_valid arrives on the same cycle as the timeout, rx_valid wins and the command continues.
- busy = (state != IDLE).
- err_count increments on each cmd_error pulse and saturates at 255 (it does not wrap).
- At most one strobe asserts per cycle, since rx_valid is at most one per cycle.

Decomposition:
- Shared package: opcode constants (OP_TON=0x91, OP_TOFF=0x9E, OP_WAVE=0x9C, OP_IP=0x93, OP_START=0x06, OP_STOP=0x07) and WAVE_* codes. The pulse generator core uses the same package.
- Sub-module: none needed, apart from an optional spi_cmd_timeout counter if it is reused elsewhere.

Test Plan:
- Reset only -> ton_us=100, toff_us=50, waveform=0x8000, ip_set=0, err_count=0, all strobes 0.
- Bytes 0x91,0x64,0x00 -> ton_us=100 one cycle after the 3rd rx_valid; param_update is a 1-cycle pulse. Then 0x9E,0x32,0x00 -> toff_us=50.
- Bytes 0x9C,0x01,0x40 -> waveform=0x4001. Bytes 0x9C,0x05,0x00 -> waveform stays 0x4001, cmd_error pulses, err_count=1.
- Bytes 0x93,0x3C,0x00 then 0x06 -> ip_set=60, then machine_start is a single pulse. Byte 0x07 -> machine_stop pulse.
- Byte 0x93, then 0x3C, then no byte for TIMEOUT_CYCLES -> back to IDLE, busy=0, cmd_error pulse. A following 0x06 is decoded as start.
- Unknown byte 0xAA repeated 300 times -> err_count saturates at 255. sys_rst_n pulsed while in GET_HI -> immediate IDLE and default parameters restored.
